// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Fetch side of a simple in-order core. Owns the architectural PC. For each
// instruction it issues one read to instruction memory and waits for the
// acknowledge, which may take a variable number of cycles. The fetched word
// and PC+2 are then held for decode/execute until execute commits the next PC
// through a PCWr strobe. A HALT, a misaligned commit or a memory timeout parks
// the unit in a terminal HALTED state that only reset can leave.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   newPC      : next PC computed by execute
//   PCWr       : one-cycle strobe, execute commits newPC
//   Halt       : HALT decoded for the instruction being delivered
//   imem_rd    : one-cycle read request to instruction memory
//   imem_addr  : read address (always the PC register)
//   imem_ack   : memory response valid
//   imem_data  : instruction word, sampled only with imem_ack
//   Instr      : registered instruction for decode
//   PCinc      : PC+2, registered together with Instr
//   InstValid  : Instr/PCinc valid
//   Halted     : processor stopped
//   Err        : sticky error (misaligned PC or memory timeout)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] newPC,
    input  logic             PCWr,
    input  logic             Halt,
    output logic             imem_rd,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] Instr,
    output logic [WIDTH-1:0] PCinc,
    output logic             InstValid,
    output logic             Halted,
    output logic             Err
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DELIVER = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_instr;
    logic [WIDTH-1:0]   r_pcinc;
    logic               r_inst_valid;
    logic               r_halted;
    logic               r_err;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic [WIDTH-1:0]   w_pc_plus2;
    logic               w_ack_taken;
    logic               w_timeout;
    logic               w_halt_req;
    logic               w_misaligned;
    logic               w_commit;
    logic               w_imem_rd;

    // Carry-out is discarded, so 'hFFFE wraps to 'h0000.
    assign w_pc_plus2   = r_pc + WIDTH'(2);

    // Qualified events. Each one is only meaningful in its own state, which is
    // what makes PCWr/Halt/imem_ack harmless everywhere else.
    assign w_ack_taken  = (r_state == S_WAIT) && imem_ack;
    // The counter holds the number of ack-less WAIT cycles already spent; the
    // cycle that would bring it to TIMEOUT is the last one allowed.
    assign w_timeout    = (r_state == S_WAIT) && !imem_ack &&
                          (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    // Halt wins over a PCWr presented in the same cycle.
    assign w_halt_req   = (r_state == S_DELIVER) && Halt;
    assign w_misaligned = (r_state == S_DELIVER) && !Halt && PCWr && newPC[0];
    assign w_commit     = (r_state == S_DELIVER) && !Halt && PCWr && !newPC[0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of latches
    // on every path through the case statement.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_ack_taken) begin
                    w_next_state = S_DELIVER;
                end else if (w_timeout) begin
                    w_next_state = S_HALTED;
                end
            end
            S_DELIVER: begin
                if (w_halt_req || w_misaligned) begin
                    w_next_state = S_HALTED;
                end else if (w_commit) begin
                    w_next_state = S_FETCH;
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_HALTED;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // The reset state is FETCH, so the request is gated with rst_n to keep it
    // low while reset is held; it rises as soon as reset is released.
    always_comb begin
        w_imem_rd = 1'b0;
        if (r_state == S_FETCH) begin
            w_imem_rd = rst_n;
        end
    end

    // -------------------------------------------------------------------------
    // PC, instruction latch, status flags and WAIT counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_pcinc      <= '0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_err        <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_ack_taken) begin
                        r_instr      <= imem_data;
                        r_pcinc      <= w_pc_plus2;
                        r_inst_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_halted <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_DELIVER: begin
                    if (w_halt_req) begin
                        r_halted     <= 1'b1;
                        r_inst_valid <= 1'b0;
                    end else if (w_misaligned) begin
                        // PC is left pointing at the faulting instruction.
                        r_err    <= 1'b1;
                        r_halted <= 1'b1;
                    end else if (w_commit) begin
                        r_pc         <= newPC;
                        r_inst_valid <= 1'b0;
                    end
                end
                default: begin
                    // HALTED: everything frozen until reset.
                end
            endcase
        end
    end

    assign imem_rd   = w_imem_rd;
    assign imem_addr = r_pc;
    assign Instr     = r_instr;
    assign PCinc     = r_pcinc;
    assign InstValid = r_inst_valid;
    assign Halted    = r_halted;
    assign Err       = r_err;

endmodule
